// File: rtl/dealigner_if.sv
// dealigner_if: producer push side and consumer chunk-request side of the dealigner.
interface dealigner_if #(
    parameter int DATA_IN_WIDTH  = 256,
    parameter int LEN_WIDTH      = 8,
    parameter int DATA_OUT_WIDTH = 272
);
    logic                      in_valid;
    logic [DATA_IN_WIDTH-1:0]  in_data;
    logic                      in_ready;
    logic                      rd_req;
    logic [LEN_WIDTH-1:0]      rd_len;
    logic                      flush;
    logic [DATA_OUT_WIDTH-1:0] data_out;
    logic                      out_valid;
    logic                      stall;
    logic                      len_err;
    logic [6:0]                level;
    modport master (
        output in_valid, in_data, rd_req, rd_len, flush,
        input  in_ready, data_out, out_valid, stall, len_err, level
    );
    modport slave (
        input  in_valid, in_data, rd_req, rd_len, flush,
        output in_ready, data_out, out_valid, stall, len_err, level
    );
endinterface

// File: rtl/dealigner.sv
// dealigner: repacks 32-byte input words into variable-length chunks of up to 34 bytes.
// Define DEALIGNER_ZERO_PAD_EN to force data_out bits above rd_len*8 to zero.
module dealigner #(
    parameter int DATA_IN_WIDTH  = 256,
    parameter int LEN_WIDTH      = 8,
    parameter int DATA_OUT_WIDTH = 272
) (
    input logic       clk,
    input logic       reset,
    dealigner_if.slave bus
);
    localparam int IN_BYTES  = DATA_IN_WIDTH / 8;
    localparam int OUT_BYTES = DATA_OUT_WIDTH / 8;
    localparam int BUF_WIDTH = 2 * DATA_IN_WIDTH;

    logic [BUF_WIDTH-1:0]      buffer, shifted, buffer_n;
    logic [6:0]                cnt, cnt_pop, cnt_n;
    logic [LEN_WIDTH-1:0]      len;
    logic                      len_ok, fits, pop, push;
    logic [DATA_OUT_WIDTH-1:0] chunk, data_out;
    logic                      out_valid, len_err;

    // Bytes above cnt are kept zero, so a push can simply be OR-ed in after the pop.
    always_comb begin
        len      = bus.rd_len;
        len_ok   = 32'(len) <= 32'(OUT_BYTES);
        fits     = 32'(len) <= 32'(cnt);
        pop      = bus.rd_req && len_ok && fits && !bus.flush;
        push     = bus.in_valid && bus.in_ready && !bus.flush;
        shifted  = pop ? buffer >> {len, 3'b000} : buffer;
        cnt_pop  = pop ? cnt - 7'(len) : cnt;
        buffer_n = bus.flush ? '0
                 : push ? shifted | (BUF_WIDTH'(bus.in_data) << {cnt_pop, 3'b000}) : shifted;
        cnt_n    = bus.flush ? '0 : cnt_pop + (push ? 7'(IN_BYTES) : 7'd0);
`ifdef DEALIGNER_ZERO_PAD_EN
        chunk    = buffer[DATA_OUT_WIDTH-1:0] & ~({DATA_OUT_WIDTH{1'b1}} << {len, 3'b000});
`else
        chunk    = (len == '0) ? '0 : buffer[DATA_OUT_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer    <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            buffer    <= buffer_n;
            cnt       <= cnt_n;
            out_valid <= pop;
            len_err   <= bus.rd_req && !len_ok;
            if (pop) data_out <= chunk;
        end
    end

    assign bus.in_ready  = cnt <= 7'(IN_BYTES);
    assign bus.stall     = bus.rd_req && len_ok && !fits;
    assign bus.data_out  = data_out;
    assign bus.out_valid = out_valid;
    assign bus.len_err   = len_err;
    assign bus.level     = cnt;
endmodule
